dmem_arbiter: RTL and testbench

- Sits between the pipeline MEM stage and the data memory. Shares the single data-memory port between the CPU and a debug/loader port.
- The debug/loader port lets the bench or a loader preload or inspect memory while the CPU runs.
- CPU has fixed priority. The debug port has starvation protection.
- Generates the stall the pipeline needs for the memory's 1-cycle read latency and for lost arbitration.

---
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one synchronous-read RAM port between the CPU MEM stage
// and a debug/loader port. The CPU has fixed priority; a starved debug request eventually wins.
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | arbitrate; stores/debug writes complete here
  // CPU_RD | CPU load data returning from memory
  // DBG_RD | debug read data returning from memory
  typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              dbg_win;

  // Only the word-address field of the byte addresses reaches the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

  assign dbg_win = dbg_req & (~cpu_req | (starve_cnt == CNT_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (state == CPU_RD) cpu_rdata_q <= mem_rdata;
      if (state == DBG_RD) dbg_rdata_q <= mem_rdata;
    end
  end

  // Outputs are forced quiet while reset is held, even if requests are still asserted.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    cpu_stall      = 1'b0;
    dbg_ack        = 1'b0;
    cpu_rdata      = cpu_rdata_q;
    dbg_rdata      = dbg_rdata_q;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (dbg_win) begin
            mem_en         = 1'b1;
            mem_we         = dbg_we;
            mem_addr       = dbg_addr[ADDR_W+1:2];
            mem_wdata      = dbg_wdata;
            cpu_stall      = cpu_req;
            starve_cnt_nxt = '0;
            if (dbg_we) dbg_ack = 1'b1;
            else        state_nxt = DBG_RD;
          end else if (cpu_req) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr[ADDR_W+1:2];
            mem_wdata = cpu_wdata;
            if (dbg_req && (starve_cnt != CNT_MAX))
              starve_cnt_nxt = starve_cnt + 1'b1;
            if (!cpu_we) begin
              cpu_stall = 1'b1;
              state_nxt = CPU_RD;
            end
          end
        end
        CPU_RD: begin
          cpu_rdata = mem_rdata;
          state_nxt = IDLE;
        end
        DBG_RD: begin
          dbg_ack   = 1'b1;
          dbg_rdata = mem_rdata;
          cpu_stall = cpu_req;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized CPU/debug traffic,
// all checked against a transaction-level model with a shadow copy of memory.
module tb_dmem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        cpu_stall, dbg_ack, mem_en, mem_we;
  logic [9:0]  mem_addr;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Model: shadow memory, who owns the in-flight read, and how often debug has lost in a row.
  logic [31:0] shadow [1024];
  int          inflight;      // 0 none, 1 cpu load, 2 debug read
  int          losses;
  logic [31:0] pend_data, exp_cpu_rd, exp_dbg_rd;
  logic        exp_stall_q, exp_ack_q;
  logic [31:0] obs_cpu_rdata, obs_dbg_rdata;
  logic        obs_stall, obs_ack, obs_en, obs_we;
  logic [9:0]  obs_addr;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    inflight   = 0;
    losses     = 0;
    exp_cpu_rd = '0;
    exp_dbg_rd = '0;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  // One clock cycle: predict from current inputs, compare at the falling edge, advance.
  task automatic step();
    int unsigned wc, wd, e_addr;
    logic        e_en, e_we, e_stall, e_ack;
    logic [31:0] e_wdata;
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = '0; e_stall = 0; e_ack = 0;
    wc = (cpu_addr >> 2) % 1024;
    wd = (dbg_addr >> 2) % 1024;
    if (inflight == 1) begin
      exp_cpu_rd = pend_data;
      inflight   = 0;
    end else if (inflight == 2) begin
      e_ack      = 1;
      e_stall    = cpu_req;
      exp_dbg_rd = pend_data;
      inflight   = 0;
    end else if (dbg_req && (!cpu_req || losses >= STARVE)) begin
      e_en = 1; e_we = dbg_we; e_addr = wd; e_wdata = dbg_wdata; e_stall = cpu_req;
      losses = 0;
      if (dbg_we) begin
        shadow[wd] = dbg_wdata;
        e_ack = 1;
      end else begin
        pend_data = shadow[wd];
        inflight  = 2;
      end
    end else if (cpu_req) begin
      e_en = 1; e_we = cpu_we; e_addr = wc; e_wdata = cpu_wdata;
      if (dbg_req && losses < STARVE) losses++;
      if (cpu_we) shadow[wc] = cpu_wdata;
      else begin
        e_stall   = 1;
        pend_data = shadow[wc];
        inflight  = 1;
      end
    end
    @(negedge clk);
    obs_stall = cpu_stall; obs_ack = dbg_ack; obs_en = mem_en; obs_we = mem_we;
    obs_addr = mem_addr; obs_cpu_rdata = cpu_rdata; obs_dbg_rdata = dbg_rdata;
    chk("cpu_stall", 32'(obs_stall), 32'(e_stall));
    chk("dbg_ack", 32'(obs_ack), 32'(e_ack));
    chk("mem_en", 32'(obs_en), 32'(e_en));
    chk("cpu_rdata", obs_cpu_rdata, exp_cpu_rd);
    chk("dbg_rdata", obs_dbg_rdata, exp_dbg_rd);
    if (e_en) begin
      chk("mem_we", 32'(obs_we), 32'(e_we));
      chk("mem_addr", 32'(obs_addr), e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
    exp_stall_q = e_stall;
    exp_ack_q   = e_ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    reset = 1'b1;
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_ack", 32'(dbg_ack), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    reset = 1'b0;
    step();

    // CPU store then load
    set_cpu(1, 1, 32'h10, 32'hDEADBEEF);
    step();
    chk("st_addr", 32'(obs_addr), 4);
    chk("st_stall", 32'(obs_stall), 0);
    set_cpu(1, 0, 32'h10, 0);
    step();
    chk("ld_stall1", 32'(obs_stall), 1);
    step();
    chk("ld_stall2", 32'(obs_stall), 0);
    chk("ld_data", obs_cpu_rdata, 32'hDEADBEEF);
    set_cpu(0, 0, 0, 0);

    // Debug write then read with CPU idle
    set_dbg(1, 1, 32'h3C, 32'h12345678);
    step();
    chk("dw_ack", 32'(obs_ack), 1);
    chk("dw_we", 32'(obs_we), 1);
    chk("dw_addr", 32'(obs_addr), 15);
    set_dbg(1, 0, 32'h3C, 0);
    step();
    chk("dr_ack0", 32'(obs_ack), 0);
    step();
    chk("dr_ack1", 32'(obs_ack), 1);
    chk("dr_data", obs_dbg_rdata, 32'h12345678);
    set_dbg(0, 0, 0, 0);

    // Contention: two rounds of starvation against back-to-back CPU stores
    set_cpu(1, 1, 32'h200, 32'h0BADF00D);
    for (int r = 0; r < 2; r++) begin
      set_dbg(1, 1, 32'h40 + 32'(4 * r), 32'hA0 + 32'(r));
      for (int i = 0; i < 5; i++) begin
        step();
        chk("starve_ack", 32'(obs_ack), (i == 4) ? 1 : 0);
        chk("starve_stall", 32'(obs_stall), (i == 4) ? 1 : 0);
        if (i == 4) chk("starve_addr", 32'(obs_addr), 32'(16 + r));
      end
    end
    set_dbg(0, 0, 0, 0);
    step();
    chk("post_starve_stall", 32'(obs_stall), 0);
    set_cpu(0, 0, 0, 0);

    // Simultaneous first request: CPU load first, then debug read
    set_cpu(1, 0, 32'h10, 0);
    set_dbg(1, 0, 32'h3C, 0);
    step();
    chk("sim_stall1", 32'(obs_stall), 1);
    step();
    chk("sim_cpu_data", obs_cpu_rdata, 32'hDEADBEEF);
    chk("sim_ack_early", 32'(obs_ack), 0);
    set_cpu(0, 0, 0, 0);
    step();
    step();
    chk("sim_dbg_ack", 32'(obs_ack), 1);
    chk("sim_dbg_data", obs_dbg_rdata, 32'h12345678);
    set_dbg(0, 0, 0, 0);

    // Reset in the middle of a CPU load
    set_cpu(1, 0, 32'h10, 0);
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(cpu_stall), 0);
    chk("mid_rst_ack", 32'(dbg_ack), 0);
    chk("mid_rst_en", 32'(mem_en), 0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 0);
    chk("mid_rst_dbg_rdata", dbg_rdata, 0);
    @(posedge clk);
    #2;
    set_cpu(0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    step();
    chk("post_rst_ack", 32'(obs_ack), 0);
    chk("post_rst_stall", 32'(obs_stall), 0);

    // Address wrap: high address bits are ignored
    set_cpu(1, 1, 32'h1010, 32'hCAFEF00D);
    step();
    chk("wrap_addr", 32'(obs_addr), 4);
    set_cpu(1, 0, 32'h10, 0);
    step();
    step();
    chk("wrap_data", obs_cpu_rdata, 32'hCAFEF00D);
    set_cpu(0, 0, 0, 0);
    step();

    // Randomized traffic; each side keeps its request until the model says it completed
    for (int n = 0; n < 600; n++) begin
      if (!exp_stall_q)
        set_cpu($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
                $urandom);
      if (exp_ack_q || !dbg_req)
        set_dbg($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
                ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
                $urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
